// File: rtl/instr_type.sv
// Decoded instruction kinds shared by the execution and memory stages.
package instr_type;

  typedef enum logic [3:0] {
    KIND_ALU = 4'd0,
    KIND_LB  = 4'd1,
    KIND_LH  = 4'd2,
    KIND_LW  = 4'd3,
    KIND_LBU = 4'd4,
    KIND_LHU = 4'd5,
    KIND_SB  = 4'd6,
    KIND_SH  = 4'd7,
    KIND_SW  = 4'd8
  } instr_kind_t;

endpackage

// File: rtl/mem_access_ctrl_pkg.sv
// Memory-stage FSM states, store strobe patterns and alignment rule.
package mem_ctrl_pkg;
  import instr_type::*;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'hF;

  // Words need both low bits clear, halves need bit 0 clear, bytes always fit.
  function automatic logic is_misaligned(instr_kind_t kind, logic [1:0] addr_lo);
    case (kind)
      KIND_LW, KIND_SW:           is_misaligned = (addr_lo != 2'b00);
      KIND_LH, KIND_LHU, KIND_SH: is_misaligned = addr_lo[0];
      default:                    is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/register_file_params.sv
// Register file and operand widths.
package register_file_params;

  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
  localparam int OPERAND_WIDTH             = 32;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-port data-memory bus with req/ack handshake.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_load_formatter.sv
// Extracts the addressed byte/half of a read word and extends it to 32 bits.
module load_formatter
  import instr_type::*;
(
  input  instr_kind_t i_kind,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Select lane and apply sign or zero extension by load kind.
  always_comb begin
    case (i_kind)
      KIND_LB:  o_value = {{24{w_byte[7]}}, w_byte};
      KIND_LBU: o_value = {24'd0, w_byte};
      KIND_LH:  o_value = {{16{w_half[15]}}, w_half};
      KIND_LHU: o_value = {16'd0, w_half};
      default:  o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory stage: sequences loads/stores onto the data bus and emits a
// registered writeback record for every accepted instruction.
module mem_access_ctrl
  import instr_type::*;
  import register_file_params::*;
  import mem_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_input,
  input  instr_kind_t                          instr_kind_input,
  input  logic                                 write_register,
  input  logic                                 read_memory,
  input  logic                                 write_memory,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
  input  logic [OPERAND_WIDTH-1:0]             new_register_value,
  input  logic [OPERAND_WIDTH-1:0]             read_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             write_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             new_memory_value,
  output logic                                 stall_output,
  mem_access_ctrl_if.master                    bus,
  output logic                                 wb_valid,
  output logic                                 wb_write_register,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_rd_addr,
  output logic [OPERAND_WIDTH-1:0]             wb_data,
  output logic                                 misaligned,
  output logic                                 bus_error
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t                         r_state, w_state_next;
  logic [CNT_W-1:0]               r_count, w_count_next;
  logic [31:0]                    r_addr, w_addr_next;
  instr_kind_t                    r_kind, w_kind_next;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_rd, w_rd_next;
  logic                           r_we, w_we_next;
  logic [31:0]                    r_wdata, w_wdata_next;
  logic [3:0]                     r_wstrb, w_wstrb_next;

  logic                           r_wb_valid, w_wb_valid_next;
  logic                           r_wb_wr, w_wb_wr_next;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_wb_rd, w_wb_rd_next;
  logic [OPERAND_WIDTH-1:0]       r_wb_data, w_wb_data_next;
  logic                           r_misaligned, w_misaligned_next;
  logic                           r_bus_error, w_bus_error_next;

  logic [31:0]                    w_in_addr;
  logic [31:0]                    w_load_value;

  assign w_in_addr = write_memory ? write_memory_address : read_memory_address;

  load_formatter u_load_formatter (
    .i_kind    (r_kind),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (bus.mem_rdata),
    .o_value   (w_load_value)
  );

  // Next-state, latch and writeback-record decisions.
  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_addr_next       = r_addr;
    w_kind_next       = r_kind;
    w_rd_next         = r_rd;
    w_we_next         = r_we;
    w_wdata_next      = r_wdata;
    w_wstrb_next      = r_wstrb;
    w_wb_valid_next   = 1'b0;
    w_wb_wr_next      = 1'b0;
    w_wb_rd_next      = '0;
    w_wb_data_next    = '0;
    w_misaligned_next = 1'b0;
    w_bus_error_next  = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_input) begin
          if (read_memory || write_memory) begin
            if (is_misaligned(instr_kind_input, w_in_addr[1:0])) begin
              w_wb_valid_next   = 1'b1;
              w_wb_rd_next      = rd_addr_input;
              w_misaligned_next = 1'b1;
            end else begin
              w_state_next = REQ;
              w_count_next = '0;
              w_addr_next  = w_in_addr;
              w_kind_next  = instr_kind_input;
              w_rd_next    = rd_addr_input;
              w_we_next    = write_memory;
              if (!write_memory) begin
                w_wdata_next = '0;
                w_wstrb_next = 4'h0;
              end else begin
                case (instr_kind_input)
                  KIND_SB: begin
                    w_wdata_next = {4{new_memory_value[7:0]}};
                    w_wstrb_next = STRB_BYTE << w_in_addr[1:0];
                  end
                  KIND_SH: begin
                    w_wdata_next = {2{new_memory_value[15:0]}};
                    w_wstrb_next = STRB_HALF << w_in_addr[1:0];
                  end
                  default: begin
                    w_wdata_next = new_memory_value;
                    w_wstrb_next = STRB_WORD;
                  end
                endcase
              end
            end
          end else begin
            w_wb_valid_next = 1'b1;
            w_wb_wr_next    = write_register;
            w_wb_rd_next    = rd_addr_input;
            w_wb_data_next  = new_register_value;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          // An ack always beats a timeout landing in the same cycle.
          w_state_next    = IDLE;
          w_wb_valid_next = 1'b1;
          w_wb_rd_next    = r_rd;
          if (!r_we) begin
            w_wb_wr_next   = 1'b1;
            w_wb_data_next = w_load_value;
          end
        end else if (ACK_TIMEOUT > 0) begin
          if (r_count == CNT_LAST) begin
            w_state_next     = IDLE;
            w_wb_valid_next  = 1'b1;
            w_wb_rd_next     = r_rd;
            w_bus_error_next = 1'b1;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, latched transaction and writeback registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_addr       <= '0;
      r_kind       <= KIND_ALU;
      r_rd         <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= 4'h0;
      r_wb_valid   <= 1'b0;
      r_wb_wr      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_addr       <= w_addr_next;
      r_kind       <= w_kind_next;
      r_rd         <= w_rd_next;
      r_we         <= w_we_next;
      r_wdata      <= w_wdata_next;
      r_wstrb      <= w_wstrb_next;
      r_wb_valid   <= w_wb_valid_next;
      r_wb_wr      <= w_wb_wr_next;
      r_wb_rd      <= w_wb_rd_next;
      r_wb_data    <= w_wb_data_next;
      r_misaligned <= w_misaligned_next;
      r_bus_error  <= w_bus_error_next;
    end
  end

  // Bus outputs are driven only while a request is live so idle cycles read as zero.
  assign stall_output  = (r_state != IDLE);
  assign bus.mem_req   = (r_state == REQ);
  assign bus.mem_we    = (r_state == REQ) & r_we;
  assign bus.mem_addr  = (r_state == REQ) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata = (r_state == REQ) ? r_wdata : 32'd0;
  assign bus.mem_wstrb = (r_state == REQ) ? r_wstrb : 4'h0;

  assign wb_valid          = r_wb_valid;
  assign wb_write_register = r_wb_wr;
  assign wb_rd_addr        = r_wb_rd;
  assign wb_data           = r_wb_data;
  assign misaligned        = r_misaligned;
  assign bus_error         = r_bus_error;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed checks of the memory-access stage against hand-computed values.
module tb_mem_access_ctrl;
  import instr_type::*;
  import register_file_params::*;

  logic clk;
  logic rst;
  logic valid_input;
  instr_kind_t instr_kind_input;
  logic write_register;
  logic read_memory;
  logic write_memory;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input;
  logic [OPERAND_WIDTH-1:0] new_register_value;
  logic [OPERAND_WIDTH-1:0] read_memory_address;
  logic [OPERAND_WIDTH-1:0] write_memory_address;
  logic [OPERAND_WIDTH-1:0] new_memory_value;
  logic stall_output;
  logic wb_valid;
  logic wb_write_register;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_rd_addr;
  logic [OPERAND_WIDTH-1:0] wb_data;
  logic misaligned;
  logic bus_error;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .valid_input          (valid_input),
    .instr_kind_input     (instr_kind_input),
    .write_register       (write_register),
    .read_memory          (read_memory),
    .write_memory         (write_memory),
    .rd_addr_input        (rd_addr_input),
    .new_register_value   (new_register_value),
    .read_memory_address  (read_memory_address),
    .write_memory_address (write_memory_address),
    .new_memory_value     (new_memory_value),
    .stall_output         (stall_output),
    .bus                  (bus),
    .wb_valid             (wb_valid),
    .wb_write_register    (wb_write_register),
    .wb_rd_addr           (wb_rd_addr),
    .wb_data              (wb_data),
    .misaligned           (misaligned),
    .bus_error            (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_kind_t k, input logic wreg, input logic rmem,
                       input logic wmem, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] data);
    valid_input          = 1'b1;
    instr_kind_input     = k;
    write_register       = wreg;
    read_memory          = rmem;
    write_memory         = wmem;
    rd_addr_input        = rd;
    new_register_value   = data;
    read_memory_address  = addr;
    write_memory_address = addr;
    new_memory_value     = data;
  endtask

  task automatic idle_inputs();
    valid_input    = 1'b0;
    read_memory    = 1'b0;
    write_memory   = 1'b0;
    write_register = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    instr_kind_input     = KIND_ALU;
    rd_addr_input        = '0;
    new_register_value   = '0;
    read_memory_address  = '0;
    write_memory_address = '0;
    new_memory_value     = '0;
    bus.mem_ack          = 1'b0;
    bus.mem_rdata        = 32'd0;

    // Reset state
    step();
    step();
    check("rst_stall", 32'(stall_output), 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    rst = 1'b1;
    step();

    // ADDI rd=3, value 5, then a back-to-back ALU op
    issue(KIND_ALU, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0000_0005);
    step();
    check("addi_wb_valid", 32'(wb_valid), 32'd1);
    check("addi_wb_data", wb_data, 32'd5);
    check("addi_wb_rd", 32'(wb_rd_addr), 32'd3);
    check("addi_wb_wr", 32'(wb_write_register), 32'd1);
    check("addi_stall", 32'(stall_output), 32'd0);
    check("addi_req", 32'(bus.mem_req), 32'd0);
    issue(KIND_ALU, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h0000_DEAD);
    step();
    check("b2b_wb_valid", 32'(wb_valid), 32'd1);
    check("b2b_wb_data", wb_data, 32'h0000_DEAD);
    idle_inputs();
    step();
    check("idle_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_wb_data", wb_data, 32'd0);

    // LB at 0x1003, ack on third REQ cycle
    issue(KIND_LB, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_1003, 32'h0);
    step();
    idle_inputs();
    check("lb_stall1", 32'(stall_output), 32'd1);
    check("lb_req", 32'(bus.mem_req), 32'd1);
    check("lb_addr", bus.mem_addr, 32'h0000_1000);
    check("lb_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("lb_we", 32'(bus.mem_we), 32'd0);
    step();
    check("lb_stall2", 32'(stall_output), 32'd1);
    step();
    check("lb_stall3", 32'(stall_output), 32'd1);
    check("lb_no_wb", 32'(wb_valid), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h80FF_0000;
    step();
    bus.mem_ack = 1'b0;
    check("lb_wb_valid", 32'(wb_valid), 32'd1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_wr", 32'(wb_write_register), 32'd1);
    check("lb_wb_rd", 32'(wb_rd_addr), 32'd9);
    check("lb_stall_end", 32'(stall_output), 32'd0);

    // LBU with the same stimulus
    issue(KIND_LBU, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_1003, 32'h0);
    step();
    idle_inputs();
    step();
    step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("lbu_wb_valid", 32'(wb_valid), 32'd1);
    check("lbu_wb_data", wb_data, 32'h0000_0080);

    // LH at 0x1002, immediate ack: upper half 0x80FF sign-extended
    issue(KIND_LH, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_1002, 32'h0);
    step();
    idle_inputs();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("lh_wb_data", wb_data, 32'hFFFF_80FF);

    // SH at 0x2002, ack in first REQ cycle
    issue(KIND_SH, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_2002, 32'h1234_ABCD);
    step();
    idle_inputs();
    check("sh_we", 32'(bus.mem_we), 32'd1);
    check("sh_wstrb", 32'(bus.mem_wstrb), 32'b1100);
    check("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    check("sh_addr", bus.mem_addr, 32'h0000_2000);
    check("sh_no_wb", 32'(wb_valid), 32'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("sh_wb_valid", 32'(wb_valid), 32'd1);
    check("sh_wb_wr", 32'(wb_write_register), 32'd0);
    check("sh_wb_data", wb_data, 32'd0);
    check("sh_req_end", 32'(bus.mem_req), 32'd0);

    // SB at 0x3001
    issue(KIND_SB, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_3001, 32'h0000_0055);
    step();
    idle_inputs();
    check("sb_wstrb", 32'(bus.mem_wstrb), 32'b0010);
    check("sb_wdata", bus.mem_wdata, 32'h5555_5555);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("sb_wb_valid", 32'(wb_valid), 32'd1);

    // Misaligned LW at 0x1001
    issue(KIND_LW, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1001, 32'h0);
    step();
    idle_inputs();
    check("mis_wb_valid", 32'(wb_valid), 32'd1);
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_wb_wr", 32'(wb_write_register), 32'd0);
    check("mis_req", 32'(bus.mem_req), 32'd0);
    check("mis_stall", 32'(stall_output), 32'd0);
    step();
    check("mis_flag_clear", 32'(misaligned), 32'd0);
    check("mis_stall2", 32'(stall_output), 32'd0);

    // Misaligned SH at 0x2001
    issue(KIND_SH, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_2001, 32'hFFFF_FFFF);
    step();
    idle_inputs();
    check("mis_sh_flag", 32'(misaligned), 32'd1);
    check("mis_sh_req", 32'(bus.mem_req), 32'd0);
    step();

    // LW with no ack: timeout after 16 request cycles, then ADDI accepted
    issue(KIND_LW, 1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_4000, 32'h0);
    step();
    idle_inputs();
    req_cycles = 0;
    for (int i = 0; i < 40 && bus.mem_req; i++) begin
      req_cycles++;
      step();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_bus_error", 32'(bus_error), 32'd1);
    check("to_wb_wr", 32'(wb_write_register), 32'd0);
    issue(KIND_ALU, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0000_0077);
    step();
    idle_inputs();
    check("to_addi_valid", 32'(wb_valid), 32'd1);
    check("to_addi_data", wb_data, 32'h0000_0077);
    check("to_addi_berr", 32'(bus_error), 32'd0);

    // Ack arriving in the last allowed cycle beats the timeout
    issue(KIND_LW, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_5000, 32'h0);
    step();
    idle_inputs();
    for (int i = 0; i < 15; i++) step();
    check("race_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ack = 1'b0;
    check("race_wb_valid", 32'(wb_valid), 32'd1);
    check("race_berr", 32'(bus_error), 32'd0);
    check("race_data", wb_data, 32'hCAFE_F00D);

    // Reset while SW is outstanding; later ack must be ignored
    issue(KIND_SW, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_6000, 32'h0000_0001);
    step();
    idle_inputs();
    check("sw_req", 32'(bus.mem_req), 32'd1);
    check("sw_wstrb", 32'(bus.mem_wstrb), 32'hF);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rstmid_req", 32'(bus.mem_req), 32'd0);
    check("rstmid_stall", 32'(stall_output), 32'd0);
    check("rstmid_wb", 32'(wb_valid), 32'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    check("late_ack_req", 32'(bus.mem_req), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
